// File: rtl/adder_operand_splitter.sv
`default_nettype none
// ============================================================================
// Module   : adder_operand_splitter
// Brief    : Splits a combined {B,A} operand stream into the adder's two
//            independent inA/inB valid/ready channels, counting completed pairs.
// Revision : 1.0 - initial release
// ============================================================================
module adder_operand_splitter #(
    parameter int DATA_IN_WIDTH = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_n,
    input  logic [2*DATA_IN_WIDTH-1:0] pair_i,
    input  logic                       pair_valid_i,
    output logic                       pair_ready_o,
    output logic [DATA_IN_WIDTH-1:0]   inA_o,
    output logic                       inA_valid_o,
    input  logic                       inA_ready_i,
    output logic [DATA_IN_WIDTH-1:0]   inB_o,
    output logic                       inB_valid_o,
    input  logic                       inB_ready_i,
    output logic [COUNT_WIDTH-1:0]     pairs_done_o,
    output logic                       busy_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BOTH   = 2'd1;
    localparam logic [1:0] c_WAIT_A = 2'd2;
    localparam logic [1:0] c_WAIT_B = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_stateNext;
    logic [2*DATA_IN_WIDTH-1:0] r_pair;
    logic [COUNT_WIDTH-1:0]     r_pairsDone;
    logic                       w_doneNow;
    logic                       w_pairFire;

    // State register, holding register and completed-pair counter.
    always_ff @(posedge clk_i) begin
        if (!arst_n) begin
            r_state     <= c_IDLE;
            r_pair      <= '0;
            r_pairsDone <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_pairFire) begin
                r_pair <= pair_i;
            end
            if (w_doneNow) begin
                r_pairsDone <= r_pairsDone + 1'b1;
            end
        end
    end

    // Next-state logic; a pair finishing this cycle may be replaced immediately.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pairFire) w_stateNext = c_BOTH;
            end
            c_BOTH: begin
                if (inA_ready_i && inB_ready_i) begin
                    w_stateNext = w_pairFire ? c_BOTH : c_IDLE;
                end else if (inA_ready_i) begin
                    w_stateNext = c_WAIT_B;
                end else if (inB_ready_i) begin
                    w_stateNext = c_WAIT_A;
                end
            end
            c_WAIT_A: begin
                if (inA_ready_i) w_stateNext = w_pairFire ? c_BOTH : c_IDLE;
            end
            c_WAIT_B: begin
                if (inB_ready_i) w_stateNext = w_pairFire ? c_BOTH : c_IDLE;
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    // Outputs; an asserted reset forces everything to its reset value at once.
    always_comb begin
        w_doneNow = 1'b0;
        case (r_state)
            c_BOTH:   w_doneNow = inA_ready_i && inB_ready_i;
            c_WAIT_A: w_doneNow = inA_ready_i;
            c_WAIT_B: w_doneNow = inB_ready_i;
            default:  w_doneNow = 1'b0;
        endcase
        pair_ready_o = arst_n && ((r_state == c_IDLE) || w_doneNow);
        w_pairFire   = pair_valid_i && pair_ready_o;
        inA_valid_o  = arst_n && ((r_state == c_BOTH) || (r_state == c_WAIT_A));
        inB_valid_o  = arst_n && ((r_state == c_BOTH) || (r_state == c_WAIT_B));
        busy_o       = arst_n && (r_state != c_IDLE);
        inA_o        = arst_n ? r_pair[DATA_IN_WIDTH-1:0] : '0;
        inB_o        = arst_n ? r_pair[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH] : '0;
        pairs_done_o = arst_n ? r_pairsDone : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_operand_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_operand_splitter
// Brief    : Directed self-checking bench for adder_operand_splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_operand_splitter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] pairData;
    logic        pairValid, readyA, readyB;
    logic        pairReady, validA, validB, busy;
    logic [7:0]  dataA, dataB;
    logic [15:0] count;
    logic        pairReady2, validA2, validB2, busy2;
    logic [7:0]  dataA2, dataB2;
    logic [3:0]  count2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    adder_operand_splitter #(.DATA_IN_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clk_i(clk), .arst_n(rstn), .pair_i(pairData), .pair_valid_i(pairValid),
        .pair_ready_o(pairReady), .inA_o(dataA), .inA_valid_o(validA),
        .inA_ready_i(readyA), .inB_o(dataB), .inB_valid_o(validB),
        .inB_ready_i(readyB), .pairs_done_o(count), .busy_o(busy));

    adder_operand_splitter #(.DATA_IN_WIDTH(8), .COUNT_WIDTH(4)) dutSmall (
        .clk_i(clk), .arst_n(rstn), .pair_i(pairData), .pair_valid_i(pairValid),
        .pair_ready_o(pairReady2), .inA_o(dataA2), .inA_valid_o(validA2),
        .inA_ready_i(readyA), .inB_o(dataB2), .inB_valid_o(validB2),
        .inB_ready_i(readyB), .pairs_done_o(count2), .busy_o(busy2));

    // Inputs change 1ns after the rising edge; checks happen mid-cycle (+4ns).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic test_reset();
        rstn = 1'b0; pairValid = 1'b1; pairData = 16'hFFFF; readyA = 1'b1; readyB = 1'b1;
        tick(); tick(); mid();
        checks++; if (pairReady !== 1'b0) begin errors++; $display("FAIL reset_pair_ready: got %b want 0", pairReady); end
        checks++; if ({validA, validB, busy} !== 3'b000) begin errors++; $display("FAIL reset_valids_busy: got %b want 000", {validA, validB, busy}); end
        checks++; if ({count, dataA, dataB} !== 32'h0) begin errors++; $display("FAIL reset_count_data: got %h want 0", {count, dataA, dataB}); end
        pairValid = 1'b0; rstn = 1'b1;
        tick(); mid();
        checks++; if ({pairReady, validA, validB, busy} !== 4'b1000) begin errors++; $display("FAIL idle_after_reset: got %b want 1000", {pairReady, validA, validB, busy}); end
        checks++; if ({validA2, validB2} !== 2'b00) begin errors++; $display("FAIL idle_small: got %b want 00", {validA2, validB2}); end
    endtask

    task automatic test_single();
        pairValid = 1'b1; pairData = 16'h3412; readyA = 1'b1; readyB = 1'b1;
        mid();
        checks++; if (pairReady !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", pairReady); end
        tick(); pairValid = 1'b0; mid();
        checks++; if ({validA, validB, dataA, dataB} !== {2'b11, 8'h12, 8'h34}) begin errors++; $display("FAIL single_beat: got %h want %h", {validA, validB, dataA, dataB}, {2'b11, 8'h12, 8'h34}); end
        checks++; if ({busy, count} !== {1'b1, 16'd0}) begin errors++; $display("FAIL single_busy_count: got %h want %h", {busy, count}, {1'b1, 16'd0}); end
        tick(); mid();
        checks++; if ({validA, validB, busy} !== 3'b000) begin errors++; $display("FAIL single_one_beat: got %b want 000", {validA, validB, busy}); end
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    endtask

    task automatic test_back_to_back();
        readyA = 1'b1; readyB = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pairValid = (k < 4);
            pairData  = {8'h40 + 8'(k), 8'h10 + 8'(k)};
            mid();
            checks++; if (pairReady !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, pairReady); end
            if (k >= 1) begin
                checks++;
                if ({validA, validB, dataA, dataB} !== {2'b11, 8'h10 + 8'(k - 1), 8'h40 + 8'(k - 1)}) begin
                    errors++; $display("FAIL b2b_beat[%0d]: got %h want %h", k, {validA, validB, dataA, dataB}, {2'b11, 8'h10 + 8'(k - 1), 8'h40 + 8'(k - 1)});
                end
            end
            tick();
        end
        pairValid = 1'b0; mid();
        checks++; if ({validA, validB} !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b want 00", {validA, validB}); end
        checks++; if (count !== 16'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", count); end
    endtask

    task automatic test_stall_b();
        pairValid = 1'b1; pairData = 16'h55AA; readyA = 1'b1; readyB = 1'b0;
        tick(); pairValid = 1'b0; mid();
        checks++; if ({validA, validB, pairReady} !== 3'b110) begin errors++; $display("FAIL stallb_both: got %b want 110", {validA, validB, pairReady}); end
        tick(); pairValid = 1'b1; pairData = 16'h7766;
        for (int c = 0; c < 2; c++) begin
            mid();
            checks++;
            if ({validA, validB, dataB, pairReady, busy} !== {2'b01, 8'h55, 2'b01}) begin
                errors++; $display("FAIL stallb_hold[%0d]: got %h want %h", c, {validA, validB, dataB, pairReady, busy}, {2'b01, 8'h55, 2'b01});
            end
            tick();
        end
        pairValid = 1'b0; readyB = 1'b1; mid();
        checks++; if ({validB, dataB, pairReady} !== {1'b1, 8'h55, 1'b1}) begin errors++; $display("FAIL stallb_release: got %h want %h", {validB, dataB, pairReady}, {1'b1, 8'h55, 1'b1}); end
        tick(); mid();
        checks++; if ({validA, validB, busy} !== 3'b000) begin errors++; $display("FAIL stallb_idle: got %b want 000", {validA, validB, busy}); end
        checks++; if (count !== 16'd6) begin errors++; $display("FAIL stallb_count: got %0d want 6", count); end
    endtask

    task automatic test_stall_a();
        pairValid = 1'b1; pairData = 16'h2211; readyA = 1'b0; readyB = 1'b1;
        tick(); pairValid = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            mid();
            checks++;
            if ({validA, validB, dataA, pairReady} !== {2'b10, 8'h11, 1'b0}) begin
                errors++; $display("FAIL stalla_hold[%0d]: got %h want %h", c, {validA, validB, dataA, pairReady}, {2'b10, 8'h11, 1'b0});
            end
            tick();
        end
        readyA = 1'b1; pairValid = 1'b1; pairData = 16'h4433; mid();
        checks++; if ({validA, validB, pairReady} !== 3'b101) begin errors++; $display("FAIL stalla_release: got %b want 101", {validA, validB, pairReady}); end
        tick(); pairValid = 1'b0; mid();
        checks++; if ({validA, validB, dataA, dataB} !== {2'b11, 8'h33, 8'h44}) begin errors++; $display("FAIL stalla_next: got %h want %h", {validA, validB, dataA, dataB}, {2'b11, 8'h33, 8'h44}); end
        checks++; if (count !== 16'd7) begin errors++; $display("FAIL stalla_count1: got %0d want 7", count); end
        tick(); mid();
        checks++; if ({count, busy} !== {16'd8, 1'b0}) begin errors++; $display("FAIL stalla_count2: got %h want %h", {count, busy}, {16'd8, 1'b0}); end
    endtask

    task automatic test_reset_mid();
        pairValid = 1'b1; pairData = 16'h9988; readyA = 1'b1; readyB = 1'b0;
        tick(); pairValid = 1'b0;
        tick(); mid();
        checks++; if ({validA, validB, busy} !== 3'b011) begin errors++; $display("FAIL rstmid_waitb: got %b want 011", {validA, validB, busy}); end
        rstn = 1'b0; #1;
        checks++; if ({validB, busy, pairReady, count} !== 19'h0) begin errors++; $display("FAIL rstmid_forced: got %h want 0", {validB, busy, pairReady, count}); end
        tick(); rstn = 1'b1; readyB = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mid();
            checks++;
            if ({validA, validB, busy, count} !== 19'h0) begin
                errors++; $display("FAIL rstmid_after[%0d]: got %h want 0", c, {validA, validB, busy, count});
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        readyA = 1'b1; readyB = 1'b1;
        for (int k = 0; k < 19; k++) begin
            pairValid = (k < 17);
            pairData  = 16'(k);
            mid();
            if (k >= 16) begin
                checks++;
                if (count2 !== 4'((k - 1) % 16)) begin
                    errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, count2, (k - 1) % 16);
                end
            end
            tick();
        end
        pairValid = 1'b0; mid();
        checks++; if (count !== 16'd17) begin errors++; $display("FAIL wrap_wide_count: got %0d want 17", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_b();
        test_stall_a();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_operand_splitter.md
Name: adder_operand_splitter

Overview:
- Transmitter side of the adder operand channels: accepts one combined stream of operand pairs {B,A} and drives the adder's two independent operand channels (inA, inB), each with its own valid/ready handshake.
- Sits between the stimulus/source stream and the adder's inA/inB FIFOs.
- Guarantees every A and B for one pair is delivered exactly once, in order, even when the two channels stall independently.
- Counts completed pairs for status and debug.

Parameters:
- DATA_IN_WIDTH, 8, width of each operand (A and B).
- COUNT_WIDTH, 16, width of the completed-pair counter.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- arst_n  input  1  reset; synchronous, active-low (sampled on clk_i rising edge).
- pair_i  input  2*DATA_IN_WIDTH  operand pair; [DATA_IN_WIDTH-1:0]=A, [2*DATA_IN_WIDTH-1:DATA_IN_WIDTH]=B.
- pair_valid_i  input  1  pair_i valid.
- pair_ready_o  output  1  pair accepted when pair_valid_i && pair_ready_o.
- inA_o  output  DATA_IN_WIDTH  operand A to adder.
- inA_valid_o  output  1  inA_o valid.
- inA_ready_i  input  1  A accepted when inA_valid_o && inA_ready_i.
- inB_o  output  DATA_IN_WIDTH  operand B to adder.
- inB_valid_o  output  1  inB_o valid.
- inB_ready_i  input  1  B accepted when inB_valid_o && inB_ready_i.
- pairs_done_o  output  COUNT_WIDTH  count of pairs with both halves delivered; wraps modulo 2^COUNT_WIDTH.
- busy_o  output  1  high while a pair is held (state != IDLE).

Behaviour:
- Storage: one holding register for {B,A}, loaded on pair handshake. inA_o/inB_o driven from it; stable while the respective valid is high.
- FSM states: IDLE (empty), BOTH (neither half sent), WAIT_A (B sent, A pending), WAIT_B (A sent, B pending).
- inA_valid_o = state in {BOTH, WAIT_A}; inB_valid_o = state in {BOTH, WAIT_B}. Both combinationally from state only; no dependence on ready inputs.
- Completion this cycle (done_now):
  - BOTH: inA_ready_i && inB_ready_i.
  - WAIT_A: inA_ready_i.
  - WAIT_B: inB_ready_i.
- pair_ready_o = (state==IDLE) || done_now. This allows back-to-back pairs with zero bubble; there is a combinational path ready_i -> pair_ready_o.
- Transitions:
  - IDLE: pair handshake -> BOTH (load register).
  - BOTH:
    - Both readies: -> BOTH if a new pair handshakes (load), else -> IDLE.
    - Only A ready: -> WAIT_B.
    - Only B ready: -> WAIT_A.
    - Neither: stay.
  - WAIT_A / WAIT_B: pending ready -> BOTH if a new pair handshakes (load), else -> IDLE; otherwise stay.
- Latency: pair accepted at cycle N -> inA_valid_o/inB_valid_o high at cycle N+1. Sustained throughput is 1 pair/cycle when both readies are held high.
- Counter: pairs_done_o increments by 1 on each cycle with done_now; it becomes visible the next cycle. It wraps from 2^COUNT_WIDTH-1 to 0 without saturation or flag.
- Each half is presented exactly once. A channel never re-asserts valid for a half already accepted.
- Reset (arst_n low at a clock edge):
  - state=IDLE, holding register=0, pairs_done_o=0.
  - Therefore inA_valid_o=0, inB_valid_o=0, busy_o=0, inA_o=0, inB_o=0.
  - pair_ready_o=0 while arst_n is low; outputs are forced to the reset state in the same cycle.
- Reset mid-operation: the held pair is discarded, including any half not yet sent. No partial pair is counted.
- pair_valid_i is ignored when pair_ready_o=0. Source-side valid/ready protocol compliance is the source's responsibility.

Test Plan:
- Reset then single pair A=8'h12, B=8'h34, both readies high -> one cycle later inA_o=8'h12 and inB_o=8'h34 with valids high for exactly 1 cycle; pairs_done_o=1.
- Stream 4 pairs back-to-back, both readies held high -> pair_ready_o stays high, 4 consecutive A/B beats with no bubble, pairs_done_o=4.
- A=8'hAA, B=8'h55; inA_ready_i high, inB_ready_i low for 3 cycles -> A accepted once, inA_valid_o drops; inB_valid_o held with inB_o=8'h55 stable; pair_ready_o=0 until B accepted; then count +1.
- Mirror case: B accepted first, A stalled 5 cycles -> WAIT_A path; no duplicate B; next pair accepted in the same cycle A completes.
- COUNT_WIDTH=4: push 17 pairs -> pairs_done_o reads 15, then 0, then 1.
- Hold a pair in WAIT_B, assert arst_n=0 for 1 cycle -> all valids 0, pairs_done_o=0, busy_o=0; the pending B is never presented after reset.
